// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals for mem_port_arbiter.
// The arbiter takes the slave view; requesters and the array take master.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_accept;
    logic          if_stall;
    logic          if_resp_valid;
    logic [DW-1:0] if_rdata;

    logic          ls_req;
    logic          ls_rw;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [3:0]    ls_id;
    logic          ls_accept;
    logic          ls_stall;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_rdata;
    logic [3:0]    ls_id_out;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_accept, if_stall, if_resp_valid, if_rdata,
        input  ls_req, ls_rw, ls_addr, ls_wdata, ls_id,
        output ls_accept, ls_stall, ls_resp_valid, ls_rdata, ls_id_out,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_accept, if_stall, if_resp_valid, if_rdata,
        output ls_req, ls_rw, ls_addr, ls_wdata, ls_id,
        input  ls_accept, ls_stall, ls_resp_valid, ls_rdata, ls_id_out,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and the LSQ for LATENCY cycles per request.
// Define ARB_LS_PRIORITY_EN to make LS win every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT     = 1'b1;
    localparam logic       SRC_IF   = 1'b0;
    localparam logic       SRC_LS   = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [0:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          src_q, src_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    id_q, id_d;
    logic          if_rv_q, if_rv_d;
    logic          ls_rv_q, ls_rv_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;
    logic [3:0]    ls_id_q, ls_id_d;

    logic          gnt_if;
    logic          gnt_ls;
    logic          idle;
    logic          done;

    assign idle = (state_q == IDLE) && !rst;
    assign done = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef ARB_LS_PRIORITY_EN
    // Fixed priority: LS always takes the port on a tie.
    always_comb begin
        gnt_ls = idle && bus.ls_req;
        gnt_if = idle && bus.if_req && !bus.ls_req;
    end
`else
    logic rr_last_q, rr_last_d;

    // Round-robin grant: on a tie the loser of the previous tie wins.
    always_comb begin
        gnt_if    = 1'b0;
        gnt_ls    = 1'b0;
        rr_last_d = rr_last_q;
        if (idle) begin
            if (bus.if_req && bus.ls_req) begin
                gnt_ls    = (rr_last_q == SRC_IF);
                gnt_if    = !gnt_ls;
                rr_last_d = gnt_ls ? SRC_LS : SRC_IF;
            end else begin
                gnt_if = bus.if_req;
                gnt_ls = bus.ls_req;
            end
        end
    end

    // Tie history; starts at IF so the first tie goes to LS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last_q <= SRC_IF;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    // Next-state: latch the winner in IDLE, count down and respond in WAIT.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        if_rv_d    = 1'b0;
        ls_rv_d    = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        ls_id_d    = ls_id_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_if || gnt_ls) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                    src_d   = gnt_ls ? SRC_LS : SRC_IF;
                    rw_d    = gnt_ls && bus.ls_rw;
                    addr_d  = gnt_ls ? bus.ls_addr : bus.if_addr;
                    wdata_d = gnt_ls ? bus.ls_wdata : '0;
                    id_d    = gnt_ls ? bus.ls_id : 4'd0;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (src_q == SRC_LS) begin
                        ls_rv_d    = 1'b1;
                        ls_rdata_d = rw_q ? '0 : bus.mem_rdata;
                        ls_id_d    = id_q;
                    end else begin
                        if_rv_d    = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            src_q      <= SRC_IF;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            id_q       <= 4'd0;
            if_rv_q    <= 1'b0;
            ls_rv_q    <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
            ls_id_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            if_rv_q    <= if_rv_d;
            ls_rv_q    <= ls_rv_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
            ls_id_q    <= ls_id_d;
        end
    end

    assign bus.if_accept     = gnt_if;
    assign bus.if_stall      = bus.if_req && !gnt_if;
    assign bus.if_resp_valid = if_rv_q;
    assign bus.if_rdata      = if_rdata_q;
    assign bus.ls_accept     = gnt_ls;
    assign bus.ls_stall      = bus.ls_req && !gnt_ls;
    assign bus.ls_resp_valid = ls_rv_q;
    assign bus.ls_rdata      = ls_rdata_q;
    assign bus.ls_id_out     = ls_id_q;
    assign bus.mem_en        = (state_q == WAIT);
    assign bus.mem_we        = done && rw_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory (unified I/D array, same shape as the 4KB cache arrays) between instruction fetch and the load/store queue.
- Arbitrates, latches the winning request, holds the memory port for a fixed LATENCY, then returns tagged data to the winner.
- Raises per-requester stall so the pipeline freezes while the port is busy.

Parameters:
- LATENCY, 2, memory access cycles per request, legal range 1..15.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request valid; held until accepted.
- if_addr  in  AW  fetch byte address.
- if_accept  out  1  fetch request taken this cycle.
- if_stall  out  1  if_req && !if_accept.
- if_resp_valid  out  1  one-cycle pulse, if_rdata valid.
- if_rdata  out  DW  fetched word.
- ls_req  in  1  LSQ request valid; held until accepted.
- ls_rw  in  1  1 = store, 0 = load.
- ls_addr  in  AW  LSQ byte address.
- ls_wdata  in  DW  store data.
- ls_id  in  4  LSQ entry tag.
- ls_accept  out  1  LSQ request taken this cycle.
- ls_stall  out  1  ls_req && !ls_accept.
- ls_resp_valid  out  1  one-cycle pulse; load data or store ack.
- ls_rdata  out  DW  load data; 0 for stores.
- ls_id_out  out  4  tag of the completing request.
- mem_en  out  1  memory port active.
- mem_we  out  1  write strobe.
- mem_addr  out  AW  latched address.
- mem_wdata  out  DW  latched store data.
- mem_rdata  in  DW  combinational read data from the array.

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, rr_last=IF so LS wins the first tie. All outputs 0, including latched addr/data/id. An in-flight request is dropped: no response is returned and no write is issued.
- FSM states: IDLE, WAIT.
- IDLE:
  - Grant is combinational. Only one requester -> it wins. Both -> round-robin: the loser of the last tie wins.
  - Winner's accept=1 this cycle. On the clock edge, latch addr, wdata, rw, id and source; cnt<=LATENCY-1; go to WAIT.
  - No request -> stay IDLE, accept=0.
- WAIT:
  - accepts=0, so both stalls follow their req.
  - mem_en=1; mem_addr/mem_wdata come from the latch.
  - cnt decrements each cycle.
  - When cnt==0: mem_we=rw_latched for this cycle only (exactly one write strobe per store). Register mem_rdata (0 for a store) into the winner's rdata; set the winner's resp_valid for the next cycle; go to IDLE.
- Timing: accept at cycle T -> resp_valid high at T+LATENCY+1, for exactly one cycle.
- The response cycle is an IDLE cycle, so a new grant may happen in the same cycle. Peak throughput is one request per LATENCY+1 cycles.
- mem_en=0 and mem_we=0 in IDLE.
- rdata and ls_id_out hold their values until the next response. if_rdata is only updated by fetch responses; ls_rdata and ls_id_out only by LS responses.
- rr_last updates only on ties.
- Requesters must keep fields stable while stalled. Fields are sampled only on the accept cycle.
- A req dropping before accept is legal; no grant occurs.
- Store writes through; a load issued after a store to the same address returns the new data.

Optional Feature:
- Macro ARB_LS_PRIORITY_EN.
- Defined: fixed priority, the LS request always wins ties; rr_last is unused and may be optimised away.
- Undefined: round-robin as specified above.

Test Plan:
- LATENCY=2, if_req only, addr 0x10, mem[4]=0xDEADBEEF -> if_accept at T0, mem_en T1-T2, if_resp_valid at T3 with if_rdata=0xDEADBEEF.
- ls store addr 0x20, wdata 0x12345678, id 5, then ls load addr 0x20, id 6 -> store ack: ls_resp_valid with id 5, rdata 0; single mem_we pulse. Load returns 0x12345678 with id 6.
- Both requesters held high after reset -> grants alternate LS, IF, LS, IF. With ARB_LS_PRIORITY_EN defined, all grants go to LS. Stalls equal req && !accept every cycle.
- New request presented on a response cycle -> accepted in that same cycle; back-to-back spacing is exactly 3 cycles.
- rst asserted mid-WAIT of a store -> outputs go to 0 immediately; no mem_we; no resp_valid after release; the next request completes normally.
- LATENCY=1 -> accept T0, resp_valid T2.
